// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit: 32-cycle shift-add or restoring divide, FIX, then DONE.
// Define MULDIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module mul_div_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [4:0]  ALUCode,
  input  logic [31:0] Y,
  input  logic [31:0] BusMuxOut,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ZHigh,
  output logic [31:0] ZLow,
  output logic        DivByZero
);

  localparam logic [4:0] OP_MUL = 5'd16;
  localparam logic [4:0] OP_DIV = 5'd15;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg;
  logic [63:0] acc_reg;
  logic [31:0] opnd_reg;
  logic [31:0] dividend_reg;
  logic        is_div_reg;
  logic        dbz_reg;
  logic        neg_a_reg;
  logic        neg_b_reg;
  logic [31:0] zhigh_reg;
  logic [31:0] zlow_reg;
  logic        div_by_zero_reg;

  logic        start_ok;
  logic        start_div;
  logic        y_neg;
  logic        b_neg;
  logic [31:0] y_mag;
  logic [31:0] b_mag;

  assign start_div = (ALUCode == OP_DIV);
  assign start_ok  = Start && ((ALUCode == OP_MUL) || start_div);

`ifdef MULDIV_SIGNED_EN
  assign y_neg = Y[31];
  assign b_neg = BusMuxOut[31];
`else
  assign y_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  assign y_mag = y_neg ? (~Y + 32'd1) : Y;
  assign b_mag = b_neg ? (~BusMuxOut + 32'd1) : BusMuxOut;

  always_ff @(posedge Clock) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start_ok) state_next = start_div ? DIV : MUL;
      MUL, DIV: if (count_reg == 5'd31) state_next = FIX;
      FIX:      state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign Busy = (state_reg != IDLE);
  assign Done = (state_reg == DONE);

  // One iteration of each algorithm; acc holds {partial, operand bits still to consume}.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[63:32]} + {1'b0, (acc_reg[0] ? opnd_reg : 32'd0)};
    mul_next  = {mul_sum, acc_reg[31:1]};
    div_shift = acc_reg[63:31];
    div_diff  = div_shift - {1'b0, opnd_reg};
    // Borrow out of bit 32 means the shifted remainder was smaller than the divisor.
    if (div_diff[32]) div_next = {div_shift[31:0], acc_reg[30:0], 1'b0};
    else              div_next = {div_diff[31:0], acc_reg[30:0], 1'b1};
  end

  logic        sign_xor;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    sign_xor = neg_a_reg ^ neg_b_reg;
    prod_fix = sign_xor ? (~acc_reg + 64'd1) : acc_reg;
    quo_fix  = sign_xor ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
    rem_fix  = neg_a_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
    if (is_div_reg) begin
      // Divide-by-zero reports the original dividend regardless of sign handling.
      fix_hi = dbz_reg ? dividend_reg : rem_fix;
      fix_lo = dbz_reg ? 32'hFFFF_FFFF : quo_fix;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_reg       <= '0;
      acc_reg         <= '0;
      opnd_reg        <= '0;
      dividend_reg    <= '0;
      is_div_reg      <= 1'b0;
      dbz_reg         <= 1'b0;
      neg_a_reg       <= 1'b0;
      neg_b_reg       <= 1'b0;
      zhigh_reg       <= '0;
      zlow_reg        <= '0;
      div_by_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start_ok) begin
          count_reg    <= '0;
          acc_reg      <= {32'd0, (start_div ? y_mag : b_mag)};
          opnd_reg     <= start_div ? b_mag : y_mag;
          dividend_reg <= Y;
          is_div_reg   <= start_div;
          dbz_reg      <= start_div && (BusMuxOut == 32'd0);
          neg_a_reg    <= y_neg;
          neg_b_reg    <= b_neg;
        end
        MUL: begin
          acc_reg   <= mul_next;
          count_reg <= count_reg + 5'd1;
        end
        DIV: begin
          acc_reg   <= div_next;
          count_reg <= count_reg + 5'd1;
        end
        FIX: begin
          zhigh_reg       <= fix_hi;
          zlow_reg        <= fix_lo;
          div_by_zero_reg <= dbz_reg;
        end
        default: ;
      endcase
    end
  end

  assign ZHigh     = zhigh_reg;
  assign ZLow      = zlow_reg;
  assign DivByZero = div_by_zero_reg;

endmodule
